// File: rtl/input_command_scheduler_pkg.sv
// ============================================================================
// Module   : input_command_scheduler_pkg
// Brief    : Shared state encodings, command ids and clog2 helper for the
//            input command scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package input_command_scheduler_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int CMD_FIRE  = 0;
    localparam int CMD_LEFT  = 1;
    localparam int CMD_RIGHT = 2;

    // Never returns less than 1 so that every derived vector has a legal width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick; search starts at ptr and wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import input_command_scheduler_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] gnt_id,
    output logic             any
);

    // Walk from the farthest offset back to ptr so the closest request wins.
    always_comb begin : p_pick
        logic [PTR_W-1:0] idx;
        gnt_id = '0;
        idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (req[idx]) begin
                gnt_id = idx;
            end
        end
    end

    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/input_command_scheduler.sv
// ============================================================================
// Module   : input_command_scheduler
// Brief    : Captures debounced button pulses as pending requests and shares
//            one valid/ready command channel via round-robin, with FIRE
//            cooldown. Optional auto-repeat under macro HOLD_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_command_scheduler
    import input_command_scheduler_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int FIRE_ID         = CMD_FIRE,
    parameter int COOLDOWN_CYCLES = 18_000_000,
    parameter int REPEAT_CYCLES   = 3_600_000
) (
    input  logic                      clk_36MHz,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_BTN-1:0]          btn_pulse,
    input  logic [N_BTN-1:0]          btn_level,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [clog2(N_BTN)-1:0]   cmd_id,
    output logic [N_BTN-1:0]          overrun
);

    localparam int ID_W = clog2(N_BTN);

    state_t             r_state;
    state_t             w_state_next;
    logic [N_BTN-1:0]   r_pending;
    logic [N_BTN-1:0]   r_overrun;
    logic [N_BTN-1:0]   w_pending_next;
    logic [N_BTN-1:0]   w_overrun_next;
    logic [N_BTN-1:0]   w_accept_vec;
    logic [N_BTN-1:0]   w_req;
    logic [N_BTN-1:0]   w_rep_fire;
    logic [N_BTN-1:0]   w_eligible;
    logic [ID_W-1:0]    r_cmd_id;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_any;
    logic               w_accept;
    logic               w_load_grant;
    logic               w_fire_block;

    assign w_accept = (r_state == OFFER) && cmd_ready;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        assign w_accept_vec[i] = w_accept && (r_cmd_id == ID_W'(i));
        assign w_eligible[i]   = r_pending[i] && !((i == FIRE_ID) && w_fire_block);
    end

    if (COOLDOWN_CYCLES > 0) begin : g_cooldown
        localparam int CD_W = clog2(COOLDOWN_CYCLES + 1);
        logic [CD_W-1:0] r_cooldown_cnt;

        always_ff @(posedge clk_36MHz) begin
            if (reset) begin
                r_cooldown_cnt <= '0;
            end else if (w_accept_vec[FIRE_ID]) begin
                r_cooldown_cnt <= CD_W'(COOLDOWN_CYCLES - 1);
            end else if (r_cooldown_cnt != '0) begin
                r_cooldown_cnt <= r_cooldown_cnt - CD_W'(1);
            end
        end

        assign w_fire_block = (r_cooldown_cnt != '0);
    end else begin : g_no_cooldown
        assign w_fire_block = 1'b0;
    end

`ifdef HOLD_REPEAT_EN
    localparam int RP_W = clog2(REPEAT_CYCLES + 1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_repeat
        logic [RP_W-1:0] r_rep_cnt;
        logic            w_rep_hit;

        assign w_rep_hit     = (r_rep_cnt == RP_W'(REPEAT_CYCLES - 1));
        assign w_rep_fire[i] = btn_level[i] && !w_accept_vec[i] && w_rep_hit;

        always_ff @(posedge clk_36MHz) begin
            if (reset || !btn_level[i] || w_accept_vec[i] || w_rep_hit) begin
                r_rep_cnt <= '0;
            end else begin
                r_rep_cnt <= r_rep_cnt + RP_W'(1);
            end
        end
    end
`else
    logic w_unused_level;
    assign w_unused_level = ^btn_level ^ REPEAT_CYCLES[0];
    assign w_rep_fire     = '0;
`endif

    // An accept and a new pulse in the same cycle re-arm the channel silently.
    assign w_req          = btn_pulse | w_rep_fire;
    assign w_pending_next = (r_pending & ~w_accept_vec) | w_req;
    assign w_overrun_next = w_req & r_pending & ~w_accept_vec;

    rr_arbiter #(
        .N_REQ (N_BTN),
        .PTR_W (ID_W)
    ) u_rr_arbiter (
        .req    (w_eligible),
        .ptr    (r_rr_ptr),
        .gnt_id (w_gnt_id),
        .any    (w_any)
    );

    always_comb begin
        w_state_next = r_state;
        w_load_grant = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && w_any) begin
                    w_state_next = OFFER;
                    w_load_grant = 1'b1;
                end
            end
            OFFER: begin
                if (cmd_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_36MHz) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_overrun <= '0;
            r_cmd_id  <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_overrun <= w_overrun_next;
            if (w_load_grant) begin
                r_cmd_id <= w_gnt_id;
            end
            if (w_accept) begin
                r_rr_ptr <= (r_cmd_id == ID_W'(N_BTN - 1)) ? '0 : r_cmd_id + ID_W'(1);
            end
        end
    end

    assign cmd_valid = (r_state == OFFER);
    assign cmd_id    = r_cmd_id;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_input_command_scheduler.sv
// ============================================================================
// Module   : tb_input_command_scheduler
// Brief    : Directed self-checking bench for input_command_scheduler
//            (COOLDOWN_CYCLES=8, REPEAT_CYCLES=5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_command_scheduler;
    import input_command_scheduler_pkg::*;

    logic       clk_36MHz = 1'b0;
    logic       reset;
    logic       enable;
    logic       cmd_ready;
    logic [2:0] btn_pulse;
    logic [2:0] btn_level;
    logic       cmd_valid;
    logic [1:0] cmd_id;
    logic [2:0] overrun;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] M_FIRE  = 3'b001 << CMD_FIRE;
    localparam logic [2:0] M_LEFT  = 3'b001 << CMD_LEFT;
    localparam logic [2:0] M_RIGHT = 3'b001 << CMD_RIGHT;

    always #5 clk_36MHz = ~clk_36MHz;

    input_command_scheduler #(
        .N_BTN           (3),
        .FIRE_ID         (CMD_FIRE),
        .COOLDOWN_CYCLES (8),
        .REPEAT_CYCLES   (5)
    ) dut (
        .clk_36MHz (clk_36MHz),
        .reset     (reset),
        .enable    (enable),
        .btn_pulse (btn_pulse),
        .btn_level (btn_level),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_id    (cmd_id),
        .overrun   (overrun)
    );

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk_36MHz);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        btn_pulse = '0;
        btn_level = '0;
        enable    = 1'b1;
        cmd_ready = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    // Drive a one-cycle pulse; returns one negedge later.
    task automatic pulse(input logic [2:0] p);
        btn_pulse = p;
        step(1);
        btn_pulse = '0;
    endtask

    initial begin
        int rep_count;
        reset     = 1'b1;
        enable    = 1'b1;
        cmd_ready = 1'b1;
        btn_pulse = '0;
        btn_level = '0;
        step(1);

        // 1: reset with pulses present
        btn_pulse = 3'b111;
        step(2);
        reset     = 1'b0;
        btn_pulse = '0;
        step(1);
        check("t1_valid",   cmd_valid, 0);
        check("t1_overrun", overrun,   0);
        check("t1_id",      cmd_id,    0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t1_no_pending", cmd_valid, 0);
        end

        // 2: single LEFT pulse latency
        pulse(M_LEFT);
        check("t2_t1", cmd_valid, 0);
        step(1);
        check("t2_t2", {cmd_valid, cmd_id}, {1'b1, 2'd1});
        step(1);
        check("t2_t3", cmd_valid, 0);

        // 3: simultaneous pulses, round-robin order and wrap
        do_reset();
        pulse(3'b111);
        for (int r = 0; r < 3; r++) begin
            step(1);
            check("t3_round1_offer", {cmd_valid, cmd_id}, {1'b1, 2'(r)});
            step(1);
            check("t3_round1_gap", cmd_valid, 0);
        end
        step(10);
        pulse(3'b111);
        for (int r = 0; r < 3; r++) begin
            step(1);
            check("t3_round2_offer", {cmd_valid, cmd_id}, {1'b1, 2'(r)});
            step(1);
            check("t3_round2_gap", cmd_valid, 0);
        end

        // 4: FIRE cooldown, LEFT unaffected
        do_reset();
        pulse(M_FIRE);
        step(1);
        check("t4_fire_first", {cmd_valid, cmd_id}, {1'b1, 2'd0});
        step(2);
        pulse(M_FIRE | M_LEFT);
        check("t4_idle", cmd_valid, 0);
        step(1);
        check("t4_left_granted", {cmd_valid, cmd_id}, {1'b1, 2'd1});
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("t4_fire_masked", cmd_valid, 0);
        end
        step(1);
        check("t4_fire_after_cd", {cmd_valid, cmd_id}, {1'b1, 2'd0});
        step(1);
        check("t4_fire_done", cmd_valid, 0);

        // 5: stall, coalesce/overrun, enable drop mid-offer
        do_reset();
        cmd_ready = 1'b0;
        pulse(M_RIGHT);
        step(1);
        for (int i = 0; i < 10; i++) begin
            check("t5_hold", {cmd_valid, cmd_id}, {1'b1, 2'd2});
            if (i == 1) check("t5_no_overrun_yet", overrun, 0);
            if (i == 3) check("t5_overrun_pulse", overrun, M_RIGHT);
            if (i == 4) check("t5_overrun_clear", overrun, 0);
            if (i == 2) btn_pulse = M_RIGHT;
            if (i == 3) btn_pulse = '0;
            if (i == 5) enable = 1'b0;
            step(1);
        end
        cmd_ready = 1'b1;
        step(1);
        check("t5_accepted", cmd_valid, 0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t5_no_extra", cmd_valid, 0);
        end

        // 7: pulse coincident with accept re-arms without overrun
        do_reset();
        pulse(M_LEFT);
        step(1);
        check("t7_offer1", {cmd_valid, cmd_id}, {1'b1, 2'd1});
        btn_pulse = M_LEFT;
        step(1);
        btn_pulse = '0;
        check("t7_gap", cmd_valid, 0);
        check("t7_no_overrun", overrun, 0);
        step(1);
        check("t7_offer2", {cmd_valid, cmd_id}, {1'b1, 2'd1});
        step(1);
        check("t7_done", cmd_valid, 0);

`ifdef HOLD_REPEAT_EN
        // 6: held RIGHT auto-repeats, stops on release
        do_reset();
        rep_count = 0;
        btn_level = M_RIGHT;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) btn_level = '0;
            step(1);
            if (cmd_valid && cmd_id == 2'd2) rep_count++;
        end
        check("t6_repeat_count", rep_count, 3);
`else
        rep_count = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
